// File: rtl/drbg_synchronizer_pkg.sv
// Shared constants, state encodings and helpers for the DRBG sequence synchronizer.
package drbg_synchronizer_pkg;

  localparam int unsigned SEQ_W               = 32;
  localparam int unsigned DEFAULT_MAX_BACKLOG = 16;
  localparam int unsigned DEFAULT_RESET_PULSE = 2;
  localparam int unsigned STATE_W             = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_COMPARE   = 3'd1;
  localparam state_t ST_CATCH_UP  = 3'd2;
  localparam state_t ST_BLOCK     = 3'd3;
  localparam state_t ST_RESTART   = 3'd4;
  localparam state_t ST_WAIT_INIT = 3'd5;

  // Signed modular distance from the current counter to the target.
  function automatic logic signed [SEQ_W-1:0] seq_distance(
    input logic [SEQ_W-1:0] target,
    input logic [SEQ_W-1:0] current
  );
    return $signed(SEQ_W'(target - current));
  endfunction

endpackage

// File: rtl/drbg_synchronizer.sv
// Steers the DRBG reseed counter onto an externally supplied sequence number by
// catching up, blocking external reseeds, or restarting the DRBG.
module drbg_synchronizer
  import drbg_synchronizer_pkg::*;
#(
  parameter int unsigned MAX_BACKLOG = DEFAULT_MAX_BACKLOG,
  parameter int unsigned RESET_PULSE = DEFAULT_RESET_PULSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic [SEQ_W-1:0] sequence_internal,
  input  logic [SEQ_W-1:0] sequence_external,
  input  logic             sequence_external_valid,
  input  logic             V,
  output logic             catch_up_mode,
  output logic             get_next_seed,
  output logic             reset_n_drbg,
  output logic             block_drbg_reseed
);

  localparam int unsigned PULSE_W = (RESET_PULSE >= 1) ? $clog2(RESET_PULSE + 1) : 1;
  localparam logic signed [SEQ_W-1:0] ZERO_D      = '0;
  localparam logic signed [SEQ_W-1:0] NEG_BACKLOG = -$signed(SEQ_W'(MAX_BACKLOG));

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   target_q, target_d;
  logic [SEQ_W-1:0]   seq_q;
  logic               outstanding_q, outstanding_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               catch_up_d, gns_d, rstn_d, block_d;
  logic signed [SEQ_W-1:0] distance_c;

  assign distance_c = seq_distance(target_q, sequence_internal);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      target_q          <= '0;
      seq_q             <= '0;
      outstanding_q     <= 1'b0;
      pulse_cnt_q       <= '0;
      catch_up_mode     <= 1'b0;
      get_next_seed     <= 1'b0;
      reset_n_drbg      <= 1'b0;
      block_drbg_reseed <= 1'b0;
    end else begin
      state_q           <= state_d;
      target_q          <= target_d;
      seq_q             <= sequence_internal;
      outstanding_q     <= outstanding_d;
      pulse_cnt_q       <= pulse_cnt_d;
      catch_up_mode     <= catch_up_d;
      get_next_seed     <= gns_d;
      reset_n_drbg      <= rstn_d;
      block_drbg_reseed <= block_d;
    end
  end

  // Next state and next output values; an outstanding request retires when the counter moves.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    outstanding_d = outstanding_q && (sequence_internal == seq_q);
    pulse_cnt_d   = pulse_cnt_q;
    catch_up_d    = 1'b0;
    gns_d         = 1'b0;
    rstn_d        = 1'b1;
    block_d       = 1'b0;

    if (sequence_external_valid) begin
      // A fresh reference overrides whatever was in progress; hold gating while it is evaluated.
      target_d   = SEQ_W'(sequence_external - SEQ_W'(V));
      state_d    = ST_COMPARE;
      catch_up_d = catch_up_mode;
      block_d    = block_drbg_reseed;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end

        ST_COMPARE: begin
          if (distance_c == ZERO_D) begin
            state_d = ST_IDLE;
          end else if (distance_c > ZERO_D) begin
            state_d    = ST_CATCH_UP;
            catch_up_d = 1'b1;
            block_d    = 1'b1;
            if (init_done && !outstanding_d) begin
              gns_d         = 1'b1;
              outstanding_d = 1'b1;
            end
          end else if (distance_c >= NEG_BACKLOG) begin
            state_d = ST_BLOCK;
            block_d = 1'b1;
          end else begin
            state_d       = ST_RESTART;
            rstn_d        = 1'b0;
            catch_up_d    = 1'b1;
            block_d       = 1'b1;
            pulse_cnt_d   = PULSE_W'(1);
            outstanding_d = 1'b0;
          end
        end

        ST_CATCH_UP: begin
          catch_up_d = 1'b1;
          block_d    = 1'b1;
          if (distance_c == ZERO_D) begin
            state_d    = ST_IDLE;
            catch_up_d = 1'b0;
            block_d    = 1'b0;
          end else if (distance_c < ZERO_D) begin
            // Counter moved past the target; let COMPARE decide between block and restart.
            state_d    = ST_COMPARE;
            catch_up_d = 1'b0;
          end else if (init_done && !outstanding_d) begin
            gns_d         = 1'b1;
            outstanding_d = 1'b1;
          end
        end

        ST_BLOCK: begin
          block_d = 1'b1;
        end

        ST_RESTART: begin
          catch_up_d    = 1'b1;
          block_d       = 1'b1;
          outstanding_d = 1'b0;
          if (pulse_cnt_q >= PULSE_W'(RESET_PULSE)) begin
            state_d = ST_WAIT_INIT;
          end else begin
            rstn_d      = 1'b0;
            pulse_cnt_d = PULSE_W'(pulse_cnt_q + PULSE_W'(1));
          end
        end

        ST_WAIT_INIT: begin
          catch_up_d    = 1'b1;
          block_d       = 1'b1;
          outstanding_d = 1'b0;
          if (init_done) begin
            state_d = ST_CATCH_UP;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drbg_synchronizer.sv
// Self-checking bench: a behavioural DRBG counter model plus a scoreboard of
// expected counter values for every get_next_seed-driven increment.
module tb_drbg_synchronizer;

  localparam int unsigned RESET_PULSE = 2;
  localparam int unsigned MAX_BACKLOG = 16;
  localparam int unsigned INIT_LAT    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic [31:0] seq_int;
  logic [31:0] seq_ext = '0;
  logic        seq_valid = 1'b0;
  logic        v = 1'b0;
  logic        catch_up_mode, get_next_seed, reset_n_drbg, block_drbg_reseed;
  logic        ext_ns = 1'b0;
  logic        gns_inc;
  logic [2:0]  init_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  drbg_synchronizer #(
    .MAX_BACKLOG(MAX_BACKLOG),
    .RESET_PULSE(RESET_PULSE)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .init_done              (init_done),
    .sequence_internal      (seq_int),
    .sequence_external      (seq_ext),
    .sequence_external_valid(seq_valid),
    .V                      (v),
    .catch_up_mode          (catch_up_mode),
    .get_next_seed          (get_next_seed),
    .reset_n_drbg           (reset_n_drbg),
    .block_drbg_reseed      (block_drbg_reseed)
  );

  // DRBG model: reset clears the counter, init takes INIT_LAT cycles, then reseeds advance it.
  always @(posedge clk) begin
    if (reset_n_drbg !== 1'b1) begin
      seq_int   <= '0;
      init_done <= 1'b0;
      init_cnt  <= '0;
      gns_inc   <= 1'b0;
    end else begin
      gns_inc <= 1'b0;
      if (!init_done) begin
        if (init_cnt == 3'(INIT_LAT - 1)) init_done <= 1'b1;
        init_cnt <= init_cnt + 3'd1;
      end else if (get_next_seed) begin
        seq_int <= seq_int + 32'd1;
        gns_inc <= 1'b1;
      end else if (ext_ns && !block_drbg_reseed) begin
        seq_int <= seq_int + 32'd1;
      end
    end
  end

  // Scoreboard: each requested increment must land on the next expected counter value.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (gns_inc === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL gns_unexpected: counter=%0d, required no requested reseed", seq_int);
      end else begin
        e = exp_q.pop_front();
        if (seq_int !== e) begin
          bad++;
          $display("FAIL gns_step: counter=%0d, required %0d", seq_int, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] ext, input logic vv);
    seq_ext   = ext;
    v         = vv;
    seq_valid = 1'b1;
    tick();
    seq_valid = 1'b0;
  endtask

  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    logic [31:0] x;
    x = lo;
    while (x != hi + 32'd1) begin
      exp_q.push_back(x);
      x = x + 32'd1;
    end
  endtask

  task automatic wait_settled(input string name);
    int n;
    repeat (4) tick();
    n = 0;
    while ((catch_up_mode || block_drbg_reseed || !reset_n_drbg) && n < 3000) begin
      tick();
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_timeout: init_done=%b, required 1", init_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total += 4;
    if (catch_up_mode !== 1'b0) begin bad++; $display("FAIL rst_catch_up: got %b, required 0", catch_up_mode); end
    if (get_next_seed !== 1'b0) begin bad++; $display("FAIL rst_gns: got %b, required 0", get_next_seed); end
    if (block_drbg_reseed !== 1'b0) begin bad++; $display("FAIL rst_block: got %b, required 0", block_drbg_reseed); end
    if (reset_n_drbg !== 1'b0) begin bad++; $display("FAIL rst_rstn: got %b, required 0", reset_n_drbg); end
    reset = 1'b0;
    tick();
    total += 2;
    if (reset_n_drbg !== 1'b1) begin bad++; $display("FAIL rel_rstn: got %b, required 1", reset_n_drbg); end
    if (catch_up_mode !== 1'b0 || block_drbg_reseed !== 1'b0) begin
      bad++;
      $display("FAIL rel_outputs: catch_up=%b block=%b, required 0 0", catch_up_mode, block_drbg_reseed);
    end
    wait_init();
  endtask

  task automatic test_catch_up();
    int lat;
    ext_ns = 1'b1;
    repeat (10) tick();
    ext_ns = 1'b0;
    total++;
    if (seq_int !== 32'd10) begin bad++; $display("FAIL idle_passthrough: counter=%0d, required 10", seq_int); end
    strobe(32'd20, 1'b1);
    push_range(32'd11, 32'd19);
    lat = 0;
    while (get_next_seed !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    total += 3;
    if (lat > 2) begin bad++; $display("FAIL gns_latency: edges after strobe=%0d, required <=2", lat); end
    if (catch_up_mode !== 1'b1) begin bad++; $display("FAIL cu_mode: got %b, required 1", catch_up_mode); end
    if (block_drbg_reseed !== 1'b1) begin bad++; $display("FAIL cu_block: got %b, required 1", block_drbg_reseed); end
    wait_settled("cu");
    total += 2;
    if (seq_int !== 32'd19) begin bad++; $display("FAIL cu_final: counter=%0d, required 19", seq_int); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL cu_pending: %0d increments missing, required 0", exp_q.size()); end
  endtask

  task automatic test_retarget();
    strobe(32'd29, 1'b0);
    push_range(32'd20, 32'd29);
    wait_settled("rt1");
    total++;
    if (seq_int !== 32'd29) begin bad++; $display("FAIL rt_first: counter=%0d, required 29", seq_int); end
    strobe(seq_int + 32'd60, 1'b0);
    push_range(32'd30, 32'd89);
    wait_settled("rt2");
    repeat (10) tick();
    total += 2;
    if (seq_int !== 32'd89) begin bad++; $display("FAIL rt_second: counter=%0d, required 89", seq_int); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL rt_pending: %0d increments missing, required 0", exp_q.size()); end
  endtask

  task automatic test_block();
    logic [31:0] base;
    int gns_hi, n;
    base = seq_int;
    strobe(base - 32'd1, 1'b0);
    repeat (3) tick();
    total += 2;
    if (block_drbg_reseed !== 1'b1) begin bad++; $display("FAIL blk_on: got %b, required 1", block_drbg_reseed); end
    if (catch_up_mode !== 1'b0) begin bad++; $display("FAIL blk_cu: got %b, required 0", catch_up_mode); end
    gns_hi = 0;
    for (int i = 0; i < 500; i++) begin
      ext_ns = ~ext_ns;
      tick();
      if (get_next_seed === 1'b1) gns_hi++;
    end
    ext_ns = 1'b0;
    total += 2;
    if (gns_hi != 0) begin bad++; $display("FAIL blk_gns: pulses=%0d, required 0", gns_hi); end
    if (seq_int !== base) begin bad++; $display("FAIL blk_hold: counter=%0d, required %0d", seq_int, base); end
    strobe(base, 1'b0);
    n = 0;
    while (block_drbg_reseed !== 1'b0 && n < 150) begin
      tick();
      n++;
    end
    total += 2;
    if (block_drbg_reseed !== 1'b0) begin bad++; $display("FAIL blk_release: block=%b after %0d cycles, required 0", block_drbg_reseed, n); end
    if (seq_int !== base) begin bad++; $display("FAIL blk_final: counter=%0d, required %0d", seq_int, base); end
  endtask

  task automatic test_restart();
    logic [31:0] base, tgt;
    int lows;
    base = seq_int;
    tgt  = base - 32'd61;
    strobe(tgt, 1'b0);
    push_range(32'd1, tgt);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reset_n_drbg === 1'b0) lows++;
    end
    total++;
    if (lows != RESET_PULSE) begin bad++; $display("FAIL rs_pulse: low cycles=%0d, required %0d", lows, RESET_PULSE); end
    wait_settled("rs");
    total += 2;
    if (seq_int !== tgt) begin bad++; $display("FAIL rs_final: counter=%0d, required %0d", seq_int, tgt); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL rs_pending: %0d increments missing, required 0", exp_q.size()); end
  endtask

  task automatic test_equal();
    logic [31:0] base;
    logic [31:0] ext_tab [2];
    logic        v_tab   [2];
    base = seq_int;
    ext_tab[0] = base;          v_tab[0] = 1'b0;
    ext_tab[1] = base + 32'd1;  v_tab[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      strobe(ext_tab[k], v_tab[k]);
      for (int i = 0; i < 10; i++) begin
        tick();
        total++;
        if (get_next_seed !== 1'b0 || block_drbg_reseed !== 1'b0 || catch_up_mode !== 1'b0) begin
          bad++;
          $display("FAIL eq_quiet%0d: gns=%b block=%b cu=%b, required 0 0 0", k, get_next_seed, block_drbg_reseed, catch_up_mode);
        end
      end
    end
    total++;
    if (seq_int !== base) begin bad++; $display("FAIL eq_counter: counter=%0d, required %0d", seq_int, base); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] base;
    base = seq_int;
    strobe(base + 32'd40, 1'b0);
    push_range(base + 32'd1, base + 32'd40);
    repeat (8) tick();
    total++;
    if (catch_up_mode !== 1'b1) begin bad++; $display("FAIL rm_active: cu=%b, required 1", catch_up_mode); end
    reset = 1'b1;
    tick();
    total += 4;
    if (catch_up_mode !== 1'b0) begin bad++; $display("FAIL rm_cu: got %b, required 0", catch_up_mode); end
    if (get_next_seed !== 1'b0) begin bad++; $display("FAIL rm_gns: got %b, required 0", get_next_seed); end
    if (block_drbg_reseed !== 1'b0) begin bad++; $display("FAIL rm_block: got %b, required 0", block_drbg_reseed); end
    if (reset_n_drbg !== 1'b0) begin bad++; $display("FAIL rm_rstn: got %b, required 0", reset_n_drbg); end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (reset_n_drbg !== 1'b1) begin bad++; $display("FAIL rm_release: rstn=%b, required 1", reset_n_drbg); end
    exp_q.delete();
    repeat (30) tick();
    total++;
    if (catch_up_mode !== 1'b0 || block_drbg_reseed !== 1'b0) begin
      bad++;
      $display("FAIL rm_abandon: cu=%b block=%b, required 0 0", catch_up_mode, block_drbg_reseed);
    end
  endtask

  initial begin
    test_reset();
    test_catch_up();
    test_retarget();
    test_block();
    test_restart();
    test_equal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
